// File: rtl/pc_branch_unit.sv
// Program counter / next-PC unit for the SISC datapath: PC register, branch targets, redirect pulse, sticky wrap flag.
// Optional taken-branch saturating counter enabled by defining PC_BRANCH_CNT_EN.
module pc_branch_unit #(
    parameter int ADDR_W = 16,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_rst,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic              br_sel,
    input  logic [IMM_W-1:0]  imm,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_prev,
    output logic              redirect,
    output logic              wrap,
    output logic [CNT_W-1:0]  br_count
);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] rel_pc;
    logic [ADDR_W-1:0] br_target;
    logic              br_load;

    // Sign-extending an ADDR_W offset to ADDR_W bits is the identity, so the
    // modular add below already performs signed relative addressing.
    // pc_out already points past the branch instruction (incremented at fetch),
    // so the offset is applied to it directly.
    assign offset    = imm[ADDR_W-1:0];
    assign seq_pc    = pc_out + 1'b1;
    assign rel_pc    = pc_out + offset;
    assign br_target = br_sel ? offset : rel_pc;
    assign br_load   = !rst && !pc_rst && !halt && pc_write && pc_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out   <= '0;
            pc_prev  <= '0;
            redirect <= 1'b0;
            wrap     <= 1'b0;
        end else if (pc_rst) begin
            pc_out   <= '0;
            pc_prev  <= '0;
            redirect <= 1'b0;
        end else if (halt || !pc_write) begin
            redirect <= 1'b0;
        end else if (pc_sel) begin
            pc_out   <= br_target;
            pc_prev  <= pc_out;
            redirect <= 1'b1;
        end else begin
            pc_out   <= seq_pc;
            pc_prev  <= pc_out;
            redirect <= 1'b0;
            if (&pc_out)
                wrap <= 1'b1;
        end
    end

`ifdef PC_BRANCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            br_count <= '0;
        else if (br_load && !(&br_count))
            br_count <= br_count + 1'b1;
    end
`else
    logic unused_br_load;
    assign unused_br_load = br_load;
    assign br_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: the driver queues hand-computed expectations, a monitor checks after each edge.
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0, pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, halt = 1'b0;
    logic [15:0] imm = '0;
    logic [15:0] pc_out, pc_prev;
    logic        redirect, wrap;
    logic [1:0]  br_count;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] prev;
        logic        redir;
        logic        wrp;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] exp_cnt = '0;

    pc_branch_unit #(.ADDR_W(16), .IMM_W(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
        .br_sel(br_sel), .imm(imm), .halt(halt), .pc_out(pc_out), .pc_prev(pc_prev),
        .redirect(redirect), .wrap(wrap), .br_count(br_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h want %h", name, field, got, want);
        end
    endtask

    // Monitor: the DUT presents a registered response after every edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "pc_out",   pc_out,            e.pc);
            chk(e.name, "pc_prev",  pc_prev,           e.prev);
            chk(e.name, "redirect", {15'd0, redirect}, {15'd0, e.redir});
            chk(e.name, "wrap",     {15'd0, wrap},     {15'd0, e.wrp});
            chk(e.name, "br_count", {14'd0, br_count}, {14'd0, e.cnt});
        end
    end

    // Drive one edge's inputs and queue the expected post-edge outputs.
    task automatic step(input string name, input logic r, input logic pr, input logic pw, input logic ps,
                        input logic bs, input logic [15:0] im, input logic h,
                        input logic [15:0] e_pc, input logic [15:0] e_prev, input logic e_redir, input logic e_wrap);
        exp_t e;
        @(negedge clk);
        rst = r; pc_rst = pr; pc_write = pw; pc_sel = ps; br_sel = bs; imm = im; halt = h;
`ifdef PC_BRANCH_CNT_EN
        if (r) exp_cnt = 2'd0;
        else if (!pr && !h && pw && ps && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
`else
        exp_cnt = 2'd0;
`endif
        e.name = name; e.pc = e_pc; e.prev = e_prev; e.redir = e_redir; e.wrp = e_wrap; e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        //    name        rst pr pw ps bs imm       h  pc        prev      rd wr
        step("reset",     1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        for (int i = 1; i <= 5; i++)
            step("seq",   0, 0, 1, 0, 0, 16'h0000, 0, 16'(i),   16'(i-1), 0, 0);
        step("abs10",     0, 0, 1, 1, 1, 16'h0010, 0, 16'h0010, 16'h0005, 1, 0);
        step("abs40",     0, 0, 1, 1, 1, 16'h0040, 0, 16'h0040, 16'h0010, 1, 0);
        step("idle",      0, 0, 0, 0, 0, 16'h1234, 0, 16'h0040, 16'h0010, 0, 0);
        step("abs20",     0, 0, 1, 1, 1, 16'h0020, 0, 16'h0020, 16'h0040, 1, 0);
        step("rel_neg",   0, 0, 1, 1, 0, 16'hFFFC, 0, 16'h001C, 16'h0020, 1, 0);
        step("absFFFE",   0, 0, 1, 1, 1, 16'hFFFE, 0, 16'hFFFE, 16'h001C, 1, 0);
        step("rel_wrap",  0, 0, 1, 1, 0, 16'h0008, 0, 16'h0006, 16'hFFFE, 1, 0);
        step("selfloop",  0, 0, 1, 1, 0, 16'h0000, 0, 16'h0006, 16'h0006, 1, 0);
        step("absFFFF",   0, 0, 1, 1, 1, 16'hFFFF, 0, 16'hFFFF, 16'h0006, 1, 0);
        step("seq_wrap",  0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFF, 0, 1);
        step("seq_post",  0, 0, 1, 0, 0, 16'h0000, 0, 16'h0001, 16'h0000, 0, 1);
        step("pc_rst",    0, 1, 1, 1, 1, 16'h0050, 0, 16'h0000, 16'h0000, 0, 1);
        step("rst_wrap",  1, 0, 1, 1, 1, 16'h0050, 0, 16'h0000, 16'h0000, 0, 0);
        step("abs30",     0, 0, 1, 1, 1, 16'h0030, 0, 16'h0030, 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++)
            step("halt",  0, 0, 1, 1, 1, 16'h0077, 1, 16'h0030, 16'h0000, 0, 0);
        step("unhalt",    0, 0, 1, 1, 1, 16'h0077, 0, 16'h0077, 16'h0030, 1, 0);
        step("seq78",     0, 0, 1, 0, 0, 16'h0000, 0, 16'h0078, 16'h0077, 0, 0);
        step("absFFFF2",  0, 0, 1, 1, 1, 16'hFFFF, 0, 16'hFFFF, 16'h0078, 1, 0);
        step("halt_seq",  0, 0, 1, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0078, 0, 0);
        step("pcrst_cnt", 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        step("rst_end",   1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        @(negedge clk);
        rst = 0; pc_write = 0; pc_sel = 0; halt = 0; pc_rst = 0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
